mem_port_arbiter: RTL and testbench

Sequential arbiter that shares the processor's single memory port between the instruction-fetch stage and the memory stage (LB/LW/SB/SW). Each requester holds a request until the arbiter returns a one-cycle done pulse. The arbiter issues exactly one transaction at a time to a variable-latency memory and drives the pipeline stall lines while a requester waits. The arbiter grants data first, alternating with fetch when both are pending, and includes a per-transaction timeout watchdog.

---
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between the
// instruction-fetch and memory stages. Data wins ties unless it had the
// previous grant, one transaction is in flight at a time, and a watchdog
// aborts transactions that never see mem_ready.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_byte,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          stallF,
  output logic          stallM,
  output logic          mem_req,
  output logic          mem_we,
  output logic          mem_byte,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          err
);

  localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, IBUSY = 2'd1, DBUSY = 2'd2} state_t;
  typedef enum logic {GNT_FETCH = 1'b0, GNT_DATA = 1'b1} grant_t;

  state_t        state_q, state_d;
  grant_t        last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic          mem_byte_q, mem_byte_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          i_done_q, i_done_d;
  logic          d_done_q, d_done_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          err_q, err_d;

  logic i_elig, d_elig, pick_data;

  // A requester in its done cycle is not eligible, so a held req cannot re-grant
  assign i_elig    = i_req & ~i_done_q;
  assign d_elig    = d_req & ~d_done_q;
  assign pick_data = d_elig & (~i_elig | (last_q != GNT_DATA));

  // Next-state: grant in IDLE, complete or time out while busy
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_byte_d  = mem_byte_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (pick_data) begin
          state_d     = DBUSY;
          last_d      = GNT_DATA;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_byte_d  = d_byte;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
        end else if (i_elig) begin
          state_d     = IBUSY;
          last_d      = GNT_FETCH;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_byte_d  = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
        end
      end
      IBUSY, DBUSY: begin
        if (mem_ready) begin
          if (state_q == DBUSY) begin
            d_rdata_d = mem_rdata;
            d_done_d  = 1'b1;
          end else begin
            i_rdata_d = mem_rdata;
            i_done_d  = 1'b1;
          end
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          if (state_q == DBUSY) begin
            d_rdata_d = '0;
            d_done_d  = 1'b1;
          end else begin
            i_rdata_d = '0;
            i_done_d  = 1'b1;
          end
          err_d     = 1'b1;
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs, synchronous reset abandons any transaction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= GNT_FETCH;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_byte_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_byte_q  <= mem_byte_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_byte  = mem_byte_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  assign stallF    = i_req & ~i_done_q;
  assign stallM    = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: transaction-level reference model drives the
// memory side, predicts grants and completions, and queues expected read data
// for a separate monitor that checks each done pulse.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  localparam int NONE  = 0;
  localparam int FETCH = 1;
  localparam int DATA  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_done;
  logic          d_req, d_we, d_byte;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          stallF, stallM;
  logic          mem_req, mem_we, mem_byte;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .stallF(stallF), .stallM(stallM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the port, how many busy cycles so far, the
  // latency the memory was told to use, and what the grant must look like
  int          srv = NONE;
  int          nbusy = 0;
  int          lat = 1;
  bit          last_data = 1'b0;
  bit          err_m = 1'b0;
  bit          idone_now = 1'b0;
  bit          ddone_now = 1'b0;
  bit          ie, de;
  logic [31:0] g_addr, g_wdata;
  bit          g_we, g_byte;
  logic [31:0] exp_iq[$];
  logic [31:0] exp_dq[$];
  bit          model_on = 1'b0;
  int          force_lat = 0;
  bit          force_data_en = 1'b0;
  logic [31:0] force_data = '0;
  bit          spur_en = 1'b0;
  bit          spur_once = 1'b0;
  int          mreq_cnt = 0;
  int          stallf_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn();
    nbusy = 1;
    lat   = (force_lat != 0) ? force_lat : int'($urandom_range(1, TO + 1));
  endtask

  // Memory responder plus per-cycle protocol checks against the model
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (srv != NONE && nbusy == lat) begin
        mem_ready = 1'b1;
        mem_rdata = force_data_en ? force_data : $urandom;
      end else if (srv == NONE && (spur_once || (spur_en && $urandom_range(0, 7) == 0))) begin
        mem_ready = 1'b1;
        mem_rdata = $urandom;
        spur_once = 1'b0;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
      @(negedge clk);
      if (model_on) begin
        chk("mem_req", 32'(mem_req), 32'(srv != NONE));
        if (srv != NONE) begin
          chk("mem_addr", mem_addr, g_addr);
          chk("mem_we", 32'(mem_we), 32'(g_we));
          chk("mem_byte", 32'(mem_byte), 32'(g_byte));
          if (srv == DATA) chk("mem_wdata", mem_wdata, g_wdata);
        end
        chk("i_done", 32'(i_done), 32'(idone_now));
        chk("d_done", 32'(d_done), 32'(ddone_now));
        chk("stallF", 32'(stallF), 32'(i_req && !idone_now));
        chk("stallM", 32'(stallM), 32'(d_req && !ddone_now));
        chk("err", 32'(err), 32'(err_m));
        if (mem_req) mreq_cnt++;
        if (stallF) stallf_cnt++;

        if (reset) begin
          srv = NONE; nbusy = 0; last_data = 1'b0; err_m = 1'b0;
          idone_now = 1'b0; ddone_now = 1'b0;
        end else begin
          ie = i_req && !idone_now;
          de = d_req && !ddone_now;
          idone_now = 1'b0;
          ddone_now = 1'b0;
          if (srv == NONE) begin
            if (de && (!ie || !last_data)) begin
              srv = DATA; last_data = 1'b1;
              g_addr = d_addr; g_we = d_we; g_byte = d_byte; g_wdata = d_wdata;
              start_txn();
            end else if (ie) begin
              srv = FETCH; last_data = 1'b0;
              g_addr = i_addr; g_we = 1'b0; g_byte = 1'b0; g_wdata = '0;
              start_txn();
            end
          end else if (nbusy == lat) begin
            if (srv == FETCH) begin exp_iq.push_back(mem_rdata); idone_now = 1'b1; end
            else begin exp_dq.push_back(mem_rdata); ddone_now = 1'b1; end
            srv = NONE;
          end else if (nbusy == TO) begin
            if (srv == FETCH) begin exp_iq.push_back('0); idone_now = 1'b1; end
            else begin exp_dq.push_back('0); ddone_now = 1'b1; end
            err_m = 1'b1;
            srv = NONE;
          end else begin
            nbusy++;
          end
        end
      end
    end
  end

  // Scoreboard monitor: each done pulse must match the oldest queued result
  initial begin
    forever begin
      @(negedge clk);
      if (model_on) begin
        if (i_done === 1'b1) begin
          if (exp_iq.size() == 0) begin
            checks++; errors++;
            $display("FAIL i_done_extra: got pulse, required no pulse (t=%0t)", $time);
          end else chk("i_rdata", i_rdata, exp_iq.pop_front());
        end
        if (d_done === 1'b1) begin
          if (exp_dq.size() == 0) begin
            checks++; errors++;
            $display("FAIL d_done_extra: got pulse, required no pulse (t=%0t)", $time);
          end else chk("d_rdata", d_rdata, exp_dq.pop_front());
        end
      end
    end
  end

  task automatic wait_i_done(input int budget);
    int n = 0;
    while (!idone_now && n < budget) begin tick(); n++; end
    if (!idone_now) begin
      checks++; errors++;
      $display("FAIL wait_i_done: no fetch completion in %0d cycles, required one", budget);
    end
  endtask

  task automatic wait_d_done(input int budget);
    int n = 0;
    while (!ddone_now && n < budget) begin tick(); n++; end
    if (!ddone_now) begin
      checks++; errors++;
      $display("FAIL wait_d_done: no data completion in %0d cycles, required one", budget);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_byte", 32'(mem_byte), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_i_done", 32'(i_done), 32'h0);
    chk("rst_d_done", 32'(d_done), 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    reset = 1'b0;
    model_on = 1'b1;

    // Single fetch, memory ready in the 3rd request cycle
    force_lat = 3; force_data_en = 1'b1; force_data = 32'h00A00093;
    mreq_cnt = 0; stallf_cnt = 0;
    i_addr = 32'h40; i_req = 1'b1;
    wait_i_done(20);
    chk("fetch_rdata", i_rdata, 32'h00A00093);
    i_req = 1'b0;
    tick(); tick();
    chk("fetch_mreq_cycles", mreq_cnt, 3);
    chk("fetch_stall_cycles", stallf_cnt, 4);

    // Simultaneous requests from reset: data store first, then fetch,
    // then a load raised during the fetch
    do_reset();
    force_lat = 2; force_data_en = 1'b0;
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b1; d_byte = 1'b1; d_addr = 32'h104; d_wdata = 32'hFF;
    wait_d_done(20);
    d_req = 1'b0;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h108; d_wdata = 32'h0;
    wait_i_done(20);
    i_req = 1'b0;
    wait_d_done(20);
    d_req = 1'b0;
    tick();

    // Zero-wait memory with fetch request held across three completions
    force_lat = 1;
    mreq_cnt = 0;
    i_req = 1'b1; i_addr = 32'h1000;
    for (int k = 0; k < 3; k++) begin
      wait_i_done(10);
      if (k == 2) i_req = 1'b0;
      else i_addr = i_addr + 32'h4;
      tick();
    end
    tick();
    chk("zw_mreq_cycles", mreq_cnt, 3);

    // Watchdog: memory never answers
    force_lat = TO + 1;
    mreq_cnt = 0;
    d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h300;
    wait_d_done(20);
    chk("to_d_rdata", d_rdata, 32'h0);
    chk("to_err", 32'(err), 32'h1);
    d_req = 1'b0;
    tick(); tick(); tick();
    chk("to_mreq_cycles", mreq_cnt, TO);
    chk("to_err_sticky", 32'(err), 32'h1);

    // Memory answers in the last allowed cycle: normal completion
    do_reset();
    force_lat = TO; force_data_en = 1'b1; force_data = 32'hCAFEF00D;
    d_req = 1'b1; d_addr = 32'h304;
    wait_d_done(20);
    chk("late_d_rdata", d_rdata, 32'hCAFEF00D);
    chk("late_err", 32'(err), 32'h0);
    d_req = 1'b0;
    tick();

    // Reset in the 2nd busy cycle, then a stray mem_ready while idle
    force_lat = 3; force_data = 32'h12345678;
    i_req = 1'b1; i_addr = 32'h500;
    n = 0;
    while (!(srv != NONE && nbusy == 2) && n < 10) begin tick(); n++; end
    if (!(srv != NONE && nbusy == 2)) begin
      checks++; errors++;
      $display("FAIL rst_mid_wait: no 2nd busy cycle in 10 cycles, required one");
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    spur_once = 1'b1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mid_err", 32'(err), 32'h0);
    wait_i_done(20);
    chk("rst_mid_regrant_rdata", i_rdata, 32'h12345678);
    i_req = 1'b0;
    tick();

    // Randomized traffic with random latency, timeouts and stray readies
    do_reset();
    force_lat = 0; force_data_en = 1'b0; spur_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (i_req) begin
        if (idone_now) begin
          if ($urandom_range(0, 1) == 1) i_req = 1'b0;
          else i_addr = $urandom;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        i_req = 1'b1; i_addr = $urandom;
      end
      if (d_req) begin
        if (ddone_now) begin
          if ($urandom_range(0, 1) == 1) d_req = 1'b0;
          else begin
            d_we = 1'($urandom_range(0, 1)); d_byte = 1'($urandom_range(0, 1));
            d_addr = $urandom; d_wdata = $urandom;
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_byte = 1'($urandom_range(0, 1));
        d_addr = $urandom; d_wdata = $urandom;
      end
      tick();
    end
    n = 0;
    while ((i_req || d_req || srv != NONE) && n < 100) begin
      if (i_req && idone_now) i_req = 1'b0;
      if (d_req && ddone_now) d_req = 1'b0;
      tick();
      n++;
    end
    if (i_req || d_req || srv != NONE) begin
      checks++; errors++;
      $display("FAIL drain: requests still pending after 100 cycles, required none");
    end
    tick(); tick();
    chk("iq_empty", 32'(exp_iq.size()), 32'h0);
    chk("dq_empty", 32'(exp_dq.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute guard against a hung run
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule
